stream_mux_rr: RTL and testbench

- Parametrised N-channel, W-bit mux; next generation of the 4:1 combinational mux.
- Adds valid/ready handshakes per input and on the output.
- Selects the channel by round-robin arbitration instead of an external `sel`, and registers the result in one output stage.
- Sits between several producers and one consumer, e.g. merging request streams into a single datapath.

---
 rtl/stream_mux_rr_pkg.sv | 20 ++
 rtl/stream_mux_rr_pick.sv | 61 ++++++
 rtl/stream_mux_rr.sv | 98 +++++++++
 tb/tb_stream_mux_rr.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_rr_pkg.sv
// stream_mux_pkg: shared defaults and index helpers for the round-robin
// stream mux (stream_mux_rr) and its arbiter (rr_pick).
package stream_mux_pkg;

  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 4;

  // Modulo-n increment: returns idx+1, wrapping to 0 after n-1.
  // Works for any n >= 1, including non-power-of-2 values.
  function automatic logic [31:0] next_idx(input logic [31:0] idx, input logic [31:0] n);
    logic [31:0] res_v;
    if (idx >= (n - 32'd1)) begin
      res_v = 32'd0;
    end else begin
      res_v = idx + 32'd1;
    end
    return res_v;
  endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// rr_pick: combinational arbiter for stream_mux_rr.
// Default build: round-robin, scanning req from ptr upward with wrap mod N_CH.
// STREAM_MUX_RR_FIXED_PRIO_EN: fixed priority, lowest valid index wins and
// ptr is ignored.
module rr_pick #(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

`ifdef STREAM_MUX_RR_FIXED_PRIO_EN
  logic unused_ptr_s;
  assign unused_ptr_s = ^ptr;

  // Lowest-index requester wins; scan high to low so the lowest one lands last.
  always_comb begin
    gnt_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_idx = SEL_W'(i);
      end else begin
        gnt_idx = gnt_idx;
      end
    end
  end
`else
  // Scan ptr, ptr+1, ... wrapping at N_CH; first requester found wins.
  // ptr < N_CH and i < N_CH, so one conditional subtract gives the modulo.
  always_comb begin
    logic             found_v;
    logic [SEL_W:0]   sum_v;
    logic [SEL_W-1:0] idx_v;
    gnt_idx = '0;
    found_v = 1'b0;
    sum_v   = '0;
    idx_v   = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum_v = {1'b0, ptr} + (SEL_W + 1)'(i);
      if (sum_v >= (SEL_W + 1)'(N_CH)) begin
        sum_v = sum_v - (SEL_W + 1)'(N_CH);
      end else begin
        sum_v = sum_v;
      end
      idx_v = sum_v[SEL_W-1:0];
      if (!found_v && req[idx_v]) begin
        gnt_idx = idx_v;
        found_v = 1'b1;
      end else begin
        found_v = found_v;
      end
    end
  end
`endif

  assign any = |req;

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-input, W-bit valid/ready stream mux with round-robin
// arbitration and a single registered output stage.
// Optional macro STREAM_MUX_RR_FIXED_PRIO_EN switches the arbiter to fixed
// priority (lowest index wins) and removes the round-robin pointer.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = N_CH_DEF,
  parameter  int W     = W_DEF,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_sel,
  input  logic              out_ready
);

  logic              load_s;
  logic              any_s;
  logic              xfer_s;
  logic [SEL_W-1:0]  gnt_s;
  logic [SEL_W-1:0]  ptr_s;
  logic [N_CH-1:0]   ready_s;
  logic              out_valid_r;
  logic [W-1:0]      out_data_r;
  logic [SEL_W-1:0]  out_sel_r;

  // Output register can take a word when empty or draining this cycle.
  assign load_s = !out_valid_r || out_ready;
  assign xfer_s = rst_n && load_s && any_s;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req     (in_valid),
    .ptr     (ptr_s),
    .gnt_idx (gnt_s),
    .any     (any_s)
  );

`ifdef STREAM_MUX_RR_FIXED_PRIO_EN
  assign ptr_s = '0;
`else
  logic [SEL_W-1:0] ptr_r;
  assign ptr_s = ptr_r;

  // Round-robin pointer: moves past the granted channel, only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (xfer_s) begin
      ptr_r <= SEL_W'(next_idx(32'(gnt_s), 32'(N_CH)));
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  // One-hot ready to the granted channel; silent in reset and under back-pressure.
  always_comb begin
    ready_s = '0;
    if (xfer_s) begin
      ready_s[gnt_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Output stage: load on transfer, clear valid on a drain with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= in_data[int'(gnt_s) * W +: W];
      out_sel_r   <= gnt_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_sel_r   <= out_sel_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_sel_r   <= out_sel_r;
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: table-driven directed bench for stream_mux_rr (4x4 and
// 3x4 instances) with hand-written reset, fairness and wrap sequences.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  logic [2:0]  v3_valid;
  logic [11:0] v3_data;
  logic [2:0]  v3_ready;
  logic        v3_ovalid;
  logic [3:0]  v3_odata;
  logic [1:0]  v3_osel;
  logic        v3_oready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(4), .W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  stream_mux_rr #(.N_CH(3), .W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3_valid), .in_data(v3_data),
    .in_ready(v3_ready), .out_valid(v3_ovalid), .out_data(v3_odata),
    .out_sel(v3_osel), .out_ready(v3_oready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  iv;
    logic [15:0] id;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [3:0]  exp_od;
    logic [1:0]  exp_os;
  } vec_t;

  vec_t vecs[17];
  int   sel_exp[4];
  int   v3_sel_exp[4];
  logic [3:0] v3_dat_exp[4];

  initial begin
    // round robin A,B,C,D,A
    vecs[0]  = '{4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0};
    vecs[1]  = '{4'b1111, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1};
    vecs[2]  = '{4'b1111, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2};
    vecs[3]  = '{4'b1111, 16'hDCBA, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3};
    vecs[4]  = '{4'b1111, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0};
    // load B, then back-pressure for three cycles, then release -> channel 2
    vecs[5]  = '{4'b1111, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1};
    vecs[6]  = '{4'b1111, 16'hDCBA, 1'b0, 4'b0000, 1'b1, 4'hB, 2'd1};
    vecs[7]  = '{4'b1111, 16'hDCBA, 1'b0, 4'b0000, 1'b1, 4'hB, 2'd1};
    vecs[8]  = '{4'b1111, 16'hDCBA, 1'b0, 4'b0000, 1'b1, 4'hB, 2'd1};
    vecs[9]  = '{4'b1111, 16'hDCBA, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2};
    // ptr = 3: sparse grant of channel 1, then wrap to channel 0
    vecs[10] = '{4'b0010, 16'hDCBA, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1};
    vecs[11] = '{4'b0001, 16'hDCBA, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0};
    // drain with nothing valid: valid drops, data/sel hold
    vecs[12] = '{4'b0000, 16'hDCBA, 1'b1, 4'b0000, 1'b0, 4'hA, 2'd0};
    vecs[13] = '{4'b0000, 16'hDCBA, 1'b0, 4'b0000, 1'b0, 4'hA, 2'd0};
    // idle did not move ptr (=1): {3,2} valid -> channel 2
    vecs[14] = '{4'b1100, 16'h9876, 1'b1, 4'b0100, 1'b1, 4'h8, 2'd2};
    vecs[15] = '{4'b1100, 16'h9876, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd2};
    vecs[16] = '{4'b0000, 16'h9876, 1'b0, 4'b0000, 1'b1, 4'h8, 2'd2};

`ifdef STREAM_MUX_RR_FIXED_PRIO_EN
    sel_exp    = '{1, 1, 1, 1};
    v3_sel_exp = '{0, 0, 0, 0};
    v3_dat_exp = '{4'hA, 4'hA, 4'hA, 4'hA};
`else
    sel_exp    = '{1, 2, 1, 2};
    v3_sel_exp = '{0, 1, 2, 0};
    v3_dat_exp = '{4'hA, 4'hB, 4'hC, 4'hA};
`endif

    in_valid  = 4'b0000;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    v3_valid  = 3'b000;
    v3_data   = 12'hCBA;
    v3_oready = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    chk("rst_ov",  32'(out_valid), 32'd0);
    chk("rst_od",  32'(out_data),  32'd0);
    chk("rst_os",  32'(out_sel),   32'd0);
    chk("rst_rdy", 32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef STREAM_MUX_RR_FIXED_PRIO_EN
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("v%0d_od", i), 32'(out_data),  32'(vecs[i].exp_od));
      chk($sformatf("v%0d_os", i), 32'(out_sel),   32'(vecs[i].exp_os));
    end
`endif

    // Load a word so reset hits a held output, then reset between edges.
    @(negedge clk);
    in_valid  = 4'b0001;
    in_data   = 16'hDCBA;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_ov", 32'(out_valid), 32'd1);
    @(negedge clk);
    in_valid = 4'b1000;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov",  32'(out_valid), 32'd0);
    chk("mid_rst_od",  32'(out_data),  32'd0);
    chk("mid_rst_os",  32'(out_sel),   32'd0);
    chk("mid_rst_rdy", 32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", 32'(in_ready), 32'b1000);
    @(posedge clk);
    #1;
    chk("rel_ov", 32'(out_valid), 32'd1);
    chk("rel_os", 32'(out_sel),   32'd3);
    chk("rel_od", 32'(out_data),  32'hD);

    // Hold {2,1} valid with output draining every cycle.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid  = 4'b0110;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("hold_os%0d", c), 32'(out_sel), 32'(sel_exp[c]));
    end
    @(negedge clk);
    in_valid = 4'b0000;

    // Three-channel instance: wrap 2 -> 0, never index 3.
    v3_valid  = 3'b111;
    v3_oready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("n3_os%0d", c), 32'(v3_osel),  32'(v3_sel_exp[c]));
      chk($sformatf("n3_od%0d", c), 32'(v3_odata), 32'(v3_dat_exp[c]));
    end
    v3_valid = 3'b000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
